// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
// imm_extend_stage : registered immediate-extension stage with valid/ready,
// flush and illegal-mode counter; IMM_EXT_SKID_EN adds a one-entry skid buffer.
// Revision: 1.0
// ============================================================================
module imm_extend_stage #(
  parameter int NBITS        = 32,
  parameter int IMM_BITS     = 16,
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [IMM_BITS-1:0]     i_inmediate,
  input  logic [2:0]              i_mode,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NBITS-1:0]        o_result,
  output logic                    o_mode_err,
  output logic [ERR_CNT_BITS-1:0] o_err_cnt
);

  localparam int c_S = NBITS - IMM_BITS;
  localparam logic [2:0] c_MODE_SEXT   = 3'b000;
  localparam logic [2:0] c_MODE_ZEXT   = 3'b001;
  localparam logic [2:0] c_MODE_UPPER  = 3'b010;
  localparam logic [2:0] c_MODE_BRANCH = 3'b011;
  localparam logic [2:0] c_MODE_SHAMT  = 3'b100;
  localparam logic [ERR_CNT_BITS-1:0] c_CNT_ONE = {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0]        w_sext;
  logic [NBITS-1:0]        w_result;
  logic                    w_err;
  logic                    w_accept;
  logic                    w_out_free;
  logic                    r_valid;
  logic [NBITS-1:0]        r_result;
  logic                    r_err;
  logic [ERR_CNT_BITS-1:0] r_err_cnt;

  assign w_sext = {{c_S{i_inmediate[IMM_BITS-1]}}, i_inmediate};

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (i_mode)
      c_MODE_SEXT:   w_result = w_sext;
      c_MODE_ZEXT:   w_result = {{c_S{1'b0}}, i_inmediate};
      c_MODE_UPPER:  w_result = {i_inmediate, {c_S{1'b0}}};
      c_MODE_BRANCH: w_result = {w_sext[NBITS-3:0], 2'b00};
      c_MODE_SHAMT:  w_result = {{(NBITS-5){1'b0}}, i_inmediate[10:6]};
      default:       w_err    = 1'b1;
    endcase
  end

  assign w_accept   = i_valid && o_ready && !i_flush;
  assign w_out_free = !r_valid || i_ready;

`ifdef IMM_EXT_SKID_EN
  logic             r_skid_valid;
  logic [NBITS-1:0] r_skid_result;
  logic             r_skid_err;

  // Ready depends only on skid occupancy, so no path from i_ready reaches o_ready.
  assign o_ready = !r_skid_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_err         <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_err    <= 1'b0;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_result     <= r_skid_result;
        r_err        <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= w_result;
        r_err    <= w_err;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid  <= 1'b1;
      r_skid_result <= w_result;
      r_skid_err    <= w_err;
    end
  end
`else
  assign o_ready = w_out_free;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_result;
      r_err    <= w_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + c_CNT_ONE;
    end
  end

  assign o_valid    = r_valid;
  assign o_result   = r_result;
  assign o_mode_err = r_err;
  assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/imm_extend_stage.md
# imm_extend_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It takes the instruction immediate field plus a mode select, produces the NBITS-wide operand for the execute stage, and presents it through a valid/ready handshake with flush support. Beyond plain sign, zero and upper extension, it adds branch-offset (<<2) and shift-amount modes, illegal-mode flagging with a saturating error counter, and an optional skid buffer.

## Interface
- NBITS, 32: result width; must be ≥ IMM_BITS + 2
- IMM_BITS, 16: immediate width; must be ≥ 11
- ERR_CNT_BITS, 8: width of the illegal-mode counter
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous, active-low reset; the only clock is i_clk
- i_valid  in  1  upstream immediate/mode valid
- o_ready  out  1  stage can accept this cycle
- i_inmediate  in  IMM_BITS  raw immediate field
- i_mode  in  3  extension mode
- i_flush  in  1  drop all held and incoming entries
- o_valid  out  1  o_result/o_mode_err valid
- i_ready  in  1  downstream accepts
- o_result  out  NBITS  extended operand
- o_mode_err  out  1  entry carried an illegal mode
- o_err_cnt  out  ERR_CNT_BITS  saturating count of accepted illegal modes

## Operation
- Accept: a rising edge where i_valid && o_ready && !i_flush.
- Modes (imm = i_inmediate, S = NBITS-IMM_BITS):
  - 000: sign-extend imm.
  - 001: zero-extend imm.
  - 010: {imm, S zeros}.
  - 011: sign-extend imm to NBITS, then shift left by 2; top bits are discarded.
  - 100: zero-extend imm[10:6] (shamt).
  - 101–111: illegal. Result is 0, o_mode_err = 1.
- o_err_cnt increments by 1 on each accept with an illegal mode. It saturates at all-ones and is cleared only by reset. Flushed or dropped inputs are not counted.
- Output register: updates on an accept when the output is empty or being consumed (o_valid && i_ready) in the same cycle.
- While o_valid && !i_ready, o_result and o_mode_err hold stable.
- Flush: at the next edge o_valid = 0 and the skid buffer (if present) is emptied. A simultaneous input is discarded. o_result keeps its last value. Flush wins over accept and over i_ready.

## Timing
- Latency: 1 cycle from accept to o_valid. Throughput: 1 entry/cycle when i_ready is held high.
- Reset values while i_rst_n = 0 and after release: o_valid 0, o_result 0, o_mode_err 0, o_err_cnt 0, o_ready 1, skid buffer empty.
- Reset asserted mid-stall drops all entries immediately, asynchronously.
- Without the skid buffer, o_ready = !o_valid || i_ready (combinational path from i_ready).
- With the skid buffer, o_ready is a register equal to "skid empty":
  - An accept while the output is stalled writes the skid entry, and o_ready falls on the next cycle.
  - On the edge where i_ready consumes the output, the skid entry moves to the output, and o_ready rises on the next cycle.
  - No entry is lost or duplicated.
  - Order is preserved: output, then skid, then new.

## Configuration
- IMM_EXT_SKID_EN defined: one-entry skid buffer is compiled in; o_ready is registered with no combinational path from i_ready; behaviour as above.
- IMM_EXT_SKID_EN undefined: no skid storage; o_ready is combinational as above. Data results and latency are identical.

## Test plan
- Basic modes, NBITS=32, IMM_BITS=16, i_ready=1, one accept each:
  - imm 0x8001 mode 000 -> o_result 0xFFFF8001 one cycle later.
  - imm 0x8001 mode 001 -> 0x00008001.
  - imm 0x8001 mode 010 -> 0x80010000.
- Branch and shamt modes:
  - imm 0xFFFF mode 011 -> 0xFFFFFFFC.
  - imm 0x4000 mode 011 -> 0x00010000.
  - imm 0x07C0 mode 100 -> 0x0000001F.
- Illegal modes:
  - mode 101 -> o_result 0, o_mode_err 1, o_err_cnt 0→1.
  - 300 back-to-back accepts with mode 111 -> o_err_cnt stops at 0xFF.
- Backpressure: i_valid held high with values A, B, C; i_ready low for 3 cycles.
  - o_result holds A throughout the stall.
  - After release: A, B, C in order, no duplicates.
  - With IMM_EXT_SKID_EN, o_ready falls the cycle after B is accepted.
- Flush with accept: i_flush=1 together with i_valid=1 and mode 110 -> next cycle o_valid 0, o_err_cnt unchanged; with skid, the held skid entry never appears.
- Reset mid-stall: i_rst_n pulsed low while o_valid=1, i_ready=0 -> immediately o_valid 0, o_result 0, o_err_cnt 0, o_ready 1.
